// File: rtl/rec_scheduler.sv
// rec_scheduler
//   Walks a binarized frame row by row into the digit recognizer and
//   debounces the recognizer's answer across frames.
//
//   A frame_start pulse (accepted only while idle) starts a scan: each row
//   is fetched from the row source, presented on line_a (with the previous
//   row on line_b), announced with line_pulse, and held stable for SCAN_CYC
//   cycles in total. After the last row the recognizer is given SETTLE
//   cycles, then rec_num is sampled once. A digit is published only after
//   HOLD consecutive frames agree on the same recognized value.
//
// Ports
//   video_clk    in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   frame_start  in   one-cycle frame request; counted as overrun while busy
//   row_valid    in   row source has row_data available
//   row_data     in   [LINE_W] binarized row
//   row_ready    out  high while waiting for a row (accepted when valid too)
//   line_a       out  [LINE_W] current row
//   line_b       out  [LINE_W] previous row, zero for row 0
//   row_idx      out  [8] index of the row on line_a
//   line_pulse   out  one-cycle strobe when line_a/line_b change
//   rec_num      in   [4] recognizer result, 4'hF = unrecognized
//   digit        out  [4] debounced digit
//   digit_valid  out  one-cycle pulse when digit changes
//   busy         out  high whenever a frame scan is in progress
//   overrun_cnt  out  [8] saturating count of frame_start pulses ignored
module rec_scheduler #(
  parameter int unsigned LINE_W   = 180,
  parameter int unsigned ROWS     = 240,
  parameter int unsigned SCAN_CYC = 184,
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned HOLD     = 3
) (
  input  logic              video_clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              row_valid,
  input  logic [LINE_W-1:0] row_data,
  output logic              row_ready,
  output logic [LINE_W-1:0] line_a,
  output logic [LINE_W-1:0] line_b,
  output logic [7:0]        row_idx,
  output logic              line_pulse,
  input  logic [3:0]        rec_num,
  output logic [3:0]        digit,
  output logic              digit_valid,
  output logic              busy,
  output logic [7:0]        overrun_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_SCAN,
    S_SETTLE,
    S_SAMPLE
  } state_t;

  localparam int unsigned SCAN_W  = (SCAN_CYC > 2) ? $clog2(SCAN_CYC) : 1;
  localparam int unsigned SET_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned MATCH_W = (HOLD > 1) ? $clog2(HOLD + 1) : 1;

  // SCAN occupies SCAN_CYC-1 cycles, counter runs 0..SCAN_CYC-2.
  localparam logic [SCAN_W-1:0]  SCAN_LAST = SCAN_W'(SCAN_CYC - 2);
  localparam logic [SET_W-1:0]   SET_LAST  = SET_W'(SETTLE - 1);
  localparam logic [7:0]         ROW_LAST  = 8'(ROWS - 1);
  localparam logic [MATCH_W-1:0] HOLD_M    = MATCH_W'(HOLD);
  localparam logic [3:0]         NO_DIGIT  = 4'hF;

  state_t              state_q, state_d;
  logic [7:0]          row_cnt_q, row_cnt_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [SET_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic [LINE_W-1:0]   line_a_q, line_a_d;
  logic [LINE_W-1:0]   line_b_q, line_b_d;
  logic [7:0]          row_idx_q, row_idx_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [3:0]          last_q, last_d;
  logic [3:0]          digit_q, digit_d;
  logic                digit_valid_q, digit_valid_d;
  logic [7:0]          overrun_q, overrun_d;

  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      row_cnt_q     <= '0;
      scan_cnt_q    <= '0;
      settle_cnt_q  <= '0;
      line_a_q      <= '0;
      line_b_q      <= '0;
      row_idx_q     <= '0;
      match_q       <= '0;
      last_q        <= NO_DIGIT;
      digit_q       <= NO_DIGIT;
      digit_valid_q <= 1'b0;
      overrun_q     <= '0;
    end else begin
      state_q       <= state_d;
      row_cnt_q     <= row_cnt_d;
      scan_cnt_q    <= scan_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      line_a_q      <= line_a_d;
      line_b_q      <= line_b_d;
      row_idx_q     <= row_idx_d;
      match_q       <= match_d;
      last_q        <= last_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    row_cnt_d     = row_cnt_q;
    scan_cnt_d    = scan_cnt_q;
    settle_cnt_d  = settle_cnt_q;
    line_a_d      = line_a_q;
    line_b_d      = line_b_q;
    row_idx_d     = row_idx_q;
    match_d       = match_q;
    last_d        = last_q;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    overrun_d     = overrun_q;

    // Any request outside IDLE (SAMPLE included) is dropped and counted.
    if (frame_start && (state_q != S_IDLE) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d   = S_FETCH;
          row_cnt_d = '0;
          line_b_d  = '0;
        end
      end
      S_FETCH: begin
        if (row_valid) begin
          // line_a still holds the previous frame's last row when row 0
          // arrives, so row 0 pairs with zeros instead.
          line_b_d  = (row_cnt_q == 8'd0) ? '0 : line_a_q;
          line_a_d  = row_data;
          row_idx_d = row_cnt_q;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        scan_cnt_d = '0;
        state_d    = S_SCAN;
      end
      S_SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          if (row_cnt_q == ROW_LAST) begin
            settle_cnt_d = '0;
            state_d      = S_SETTLE;
          end else begin
            row_cnt_d = row_cnt_q + 8'd1;
            state_d   = S_FETCH;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == SET_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end
      S_SAMPLE: begin
        state_d = S_IDLE;
        if (rec_num == last_q) begin
          if (match_q != HOLD_M) begin
            match_d = match_q + MATCH_W'(1);
          end
        end else begin
          match_d = MATCH_W'(1);
          last_d  = rec_num;
        end
        if ((match_d == HOLD_M) && (last_d != NO_DIGIT) && (last_d != digit_q)) begin
          digit_d       = last_d;
          digit_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign row_ready   = (state_q == S_FETCH);
  assign line_pulse  = (state_q == S_ISSUE);
  assign busy        = (state_q != S_IDLE);
  assign line_a      = line_a_q;
  assign line_b      = line_b_q;
  assign row_idx     = row_idx_q;
  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign overrun_cnt = overrun_q;

endmodule
